// File: rtl/hd_tree_pkg.sv
// Shared sizing helpers and accumulator overflow handling for the HD adder tree.
package hd_tree_pkg;

   localparam int ACC_MAX_W = 64;

   typedef logic signed [ACC_MAX_W-1:0] wide_t;

   typedef struct packed {
      logic  ovf;
      wide_t val;
   } sat_t;

   function automatic int tree_depth(input int ftsize);
      return $clog2(ftsize);
   endfunction

   function automatic int tree_width(input int input_width, input int ftsize);
      return input_width + $clog2(ftsize);
   endfunction

   function automatic bit level_registered(input int k, input int reg_every, input int depth);
      return ((k % reg_every) == 0) || (k == depth);
   endfunction

   // Out-of-range results clamp or wrap to w bits; ovf flags either case.
   function automatic sat_t sat_wrap(input wide_t full, input int w, input bit saturate);
      wide_t hi;
      wide_t lo;
      sat_t  r;
      hi    = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
      lo    = -(wide_t'(1) <<< (w - 1));
      r.ovf = (full > hi) || (full < lo);
      if (!r.ovf)
         r.val = full;
      else if (saturate)
         r.val = (full > hi) ? hi : lo;
      else
         r.val = (full <<< (ACC_MAX_W - w)) >>> (ACC_MAX_W - w);
      return r;
   endfunction

endpackage

// File: rtl/pipelined_accum_adder_tree_reduce.sv
// One adder-tree level: N lanes to N/2 pairwise sums, optionally registered with its sideband.
module tree_level_reduce #(
   parameter int N   = 2,
   parameter int W   = 8,
   parameter int SW  = 1,
   parameter bit REG = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 in_vld,
   input  logic [N*W-1:0]       din,
   input  logic [SW-1:0]        side_in,
   output logic                 out_vld,
   output logic [(N/2)*W-1:0]   dout,
   output logic [SW-1:0]        side_out
);

   logic [(N/2)*W-1:0] sum;

   // Width W already covers the full tree range, so pairwise adds cannot overflow.
   always_comb begin
      sum = '0;
      for (int i = 0; i < N/2; i++)
         sum[i*W +: W] = din[2*i*W +: W] + din[(2*i+1)*W +: W];
   end

   if (REG) begin : g_reg
      logic                 vld_p0;
      logic [(N/2)*W-1:0]   sum_p0;
      logic [SW-1:0]        side_p0;

      // ---- stage boundary: level register ----
      always_ff @(posedge clk or negedge reset) begin
         if (!reset)
            vld_p0 <= 1'b0;
         else if (en)
            vld_p0 <= in_vld;
      end

      always_ff @(posedge clk) begin
         if (en) begin
            sum_p0  <= sum;
            side_p0 <= side_in;
         end
      end

      assign out_vld  = vld_p0;
      assign dout     = sum_p0;
      assign side_out = side_p0;
   end else begin : g_comb
      logic unused_ctl;
      assign unused_ctl = ^{clk, reset, en};
      assign out_vld    = in_vld;
      assign dout       = sum;
      assign side_out   = side_in;
   end

endmodule

// File: rtl/pipelined_accum_adder_tree.sv
// Lane reduction tree feeding a framed accumulator with bias, sticky overflow and full-pipeline stall.
module pipelined_accum_adder_tree
   import hd_tree_pkg::*;
#(
   parameter int INPUT_WIDTH = 8,
   parameter int DIM_WIDTH   = 16,
   parameter int FTSIZE      = 32,
   parameter int REG_EVERY   = 1,
   parameter int SATURATE    = 0
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [FTSIZE-1:0][INPUT_WIDTH-1:0]  inputs,
   input  logic signed [DIM_WIDTH-1:0]         last_in,
   input  logic                                in_valid,
   input  logic                                in_first,
   input  logic                                in_last,
   output logic                                in_ready,
   output logic signed [DIM_WIDTH-1:0]         out,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                overflow
);

   localparam int D  = tree_depth(FTSIZE);
   localparam int TW = tree_width(INPUT_WIDTH, FTSIZE);
   localparam int SW = DIM_WIDTH + 2;

   logic en;
   assign en       = !(out_valid && !out_ready);
   assign in_ready = en;

   logic [FTSIZE*TW-1:0] lanes_ext;
   for (genvar i = 0; i < FTSIZE; i++) begin : g_ext
      assign lanes_ext[i*TW +: TW] = {{D{inputs[i][INPUT_WIDTH-1]}}, inputs[i]};
   end

   for (genvar k = 1; k <= D; k++) begin : g_lvl
      localparam int NI = FTSIZE >> (k - 1);
      logic [NI*TW-1:0]     din;
      logic [(NI/2)*TW-1:0] dout;
      logic                 vld_i;
      logic                 vld_o;
      logic [SW-1:0]        side_i;
      logic [SW-1:0]        side_o;

      if (k == 1) begin : g_src
         assign din    = lanes_ext;
         assign vld_i  = in_valid;
         assign side_i = {in_first, in_last, last_in};
      end else begin : g_src
         assign din    = g_lvl[k-1].dout;
         assign vld_i  = g_lvl[k-1].vld_o;
         assign side_i = g_lvl[k-1].side_o;
      end

      tree_level_reduce #(
         .N   (NI),
         .W   (TW),
         .SW  (SW),
         .REG (level_registered(k, REG_EVERY, D))
      ) u_reduce (
         .clk      (clk),
         .reset    (reset),
         .en       (en),
         .in_vld   (vld_i),
         .din      (din),
         .side_in  (side_i),
         .out_vld  (vld_o),
         .dout     (dout),
         .side_out (side_o)
      );
   end

   logic                        t_vld;
   logic                        t_first;
   logic                        t_last;
   logic signed [DIM_WIDTH-1:0] t_bias;
   logic [TW-1:0]               t_sum;

   assign t_vld                     = g_lvl[D].vld_o;
   assign t_sum                     = g_lvl[D].dout;
   assign {t_first, t_last, t_bias} = g_lvl[D].side_o;

   logic signed [DIM_WIDTH-1:0] acc_p1;
   logic                        open_p1;
   logic                        sticky_p1;
   logic signed [DIM_WIDTH-1:0] acc_next;
   logic                        sticky_next;
   logic                        start;
   wide_t                       full_w;
   sat_t                        res;

   // A beat with no open frame starts one, but only an explicit first carries the bias.
   always_comb begin
      start       = t_first || !open_p1;
      full_w      = wide_t'($signed(t_sum))
                  + (start   ? wide_t'(0) : wide_t'(acc_p1))
                  + (t_first ? wide_t'(t_bias) : wide_t'(0));
      res         = sat_wrap(full_w, DIM_WIDTH, SATURATE != 0);
      acc_next    = DIM_WIDTH'(res.val);
      sticky_next = (!start && sticky_p1) || res.ovf;
   end

   // ---- stage boundary: accumulator and result register ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_p1    <= '0;
         open_p1   <= 1'b0;
         sticky_p1 <= 1'b0;
         out       <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
      end else if (en) begin
         out_valid <= t_vld && t_last;
         if (t_vld) begin
            acc_p1    <= acc_next;
            open_p1   <= !t_last;
            sticky_p1 <= sticky_next;
            if (t_last) begin
               out      <= acc_next;
               overflow <= sticky_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipelined_accum_adder_tree.sv
// Directed bench: default, saturating and REG_EVERY=2 instances driven by hand-computed frames.
module tb_pipelined_accum_adder_tree;

   typedef logic [31:0][7:0] lanes_t;

   logic               clk = 1'b0;
   logic               reset;
   lanes_t             inputs_v   [3];
   logic signed [15:0] last_in_v  [3];
   logic               in_valid_v [3];
   logic               in_first_v [3];
   logic               in_last_v  [3];
   logic               in_ready_v [3];
   logic signed [15:0] out_v      [3];
   logic               out_valid_v[3];
   logic               out_ready_v[3];
   logic               overflow_v [3];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipelined_accum_adder_tree #(.INPUT_WIDTH(8), .DIM_WIDTH(16), .FTSIZE(32), .REG_EVERY(1), .SATURATE(0)) dut0 (
      .clk(clk), .reset(reset), .inputs(inputs_v[0]), .last_in(last_in_v[0]), .in_valid(in_valid_v[0]),
      .in_first(in_first_v[0]), .in_last(in_last_v[0]), .in_ready(in_ready_v[0]), .out(out_v[0]),
      .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .overflow(overflow_v[0]));

   pipelined_accum_adder_tree #(.INPUT_WIDTH(8), .DIM_WIDTH(16), .FTSIZE(32), .REG_EVERY(1), .SATURATE(1)) dut1 (
      .clk(clk), .reset(reset), .inputs(inputs_v[1]), .last_in(last_in_v[1]), .in_valid(in_valid_v[1]),
      .in_first(in_first_v[1]), .in_last(in_last_v[1]), .in_ready(in_ready_v[1]), .out(out_v[1]),
      .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .overflow(overflow_v[1]));

   pipelined_accum_adder_tree #(.INPUT_WIDTH(8), .DIM_WIDTH(16), .FTSIZE(32), .REG_EVERY(2), .SATURATE(0)) dut2 (
      .clk(clk), .reset(reset), .inputs(inputs_v[2]), .last_in(last_in_v[2]), .in_valid(in_valid_v[2]),
      .in_first(in_first_v[2]), .in_last(in_last_v[2]), .in_ready(in_ready_v[2]), .out(out_v[2]),
      .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .overflow(overflow_v[2]));

   task automatic check(input string tag, input longint obs, input longint exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic lanes_t fill(input logic signed [7:0] v);
      lanes_t l;
      for (int i = 0; i < 32; i++) l[i] = v;
      return l;
   endfunction

   // Presents a beat at the falling edge and returns right after the accepting rising edge.
   task automatic send_beat(input int idx, input lanes_t l, input logic f, input logic la,
                            input logic signed [15:0] b);
      int guard;
      @(negedge clk);
      inputs_v[idx]   = l;
      in_first_v[idx] = f;
      in_last_v[idx]  = la;
      last_in_v[idx]  = b;
      in_valid_v[idx] = 1'b1;
      guard = 0;
      while (!in_ready_v[idx] && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check("send_ready_timeout", guard, 0);
      @(posedge clk);
   endtask

   // Latency counts rising edges from the accepting edge (1) to the edge that raises out_valid.
   task automatic wait_result(input int idx, input string tag, output int lat,
                              output longint val, output longint ovf);
      lat = 1;
      @(negedge clk);
      in_valid_v[idx] = 1'b0;
      while (!out_valid_v[idx] && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check({tag, "_valid"}, out_valid_v[idx], 1);
      val = out_v[idx];
      ovf = overflow_v[idx];
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int     lat;
      int     cnt;
      longint val;
      longint ovf;
      lanes_t pat;

      reset = 1'b0;
      for (int d = 0; d < 3; d++) begin
         inputs_v[d]    = '0;
         last_in_v[d]   = '0;
         in_valid_v[d]  = 1'b0;
         in_first_v[d]  = 1'b0;
         in_last_v[d]   = 1'b0;
         out_ready_v[d] = 1'b1;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check("rst_out_valid", out_valid_v[d], 0);
         check("rst_out", out_v[d], 0);
         check("rst_overflow", overflow_v[d], 0);
      end
      reset = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 3; d++) check("rst_in_ready", in_ready_v[d], 1);

      // single-beat frame: tree sum 0, bias 3
      for (int i = 0; i < 32; i++) pat[i] = ((i % 8) < 4) ? 8'hFF : 8'h01;
      send_beat(0, pat, 1'b1, 1'b1, 16'sd3);
      wait_result(0, "t1", lat, val, ovf);
      check("t1_latency", lat, 6);
      check("t1_out", val, 3);
      check("t1_ovf", ovf, 0);
      @(negedge clk);
      check("t1_pulse_drop", out_valid_v[0], 0);

      // 3-beat frame of 127s: 3 * 32 * 127
      send_beat(0, fill(8'sd127), 1'b1, 1'b0, 16'sd0);
      send_beat(0, fill(8'sd127), 1'b0, 1'b0, 16'sd0);
      send_beat(0, fill(8'sd127), 1'b0, 1'b1, 16'sd0);
      wait_result(0, "t2", lat, val, ovf);
      check("t2_latency", lat, 6);
      check("t2_out", val, 12192);
      check("t2_ovf", ovf, 0);
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid_v[0]) cnt++;
      end
      check("t2_extra_pulses", cnt, 0);

      // 10 beats of -128: -40960 wraps to 24576 or clamps to -32768
      for (int d = 0; d < 2; d++) begin
         for (int b = 0; b < 10; b++)
            send_beat(d, fill(-8'sd128), b == 0, b == 9, 16'sd0);
         wait_result(d, "t3", lat, val, ovf);
         check(d == 0 ? "t3_wrap_out" : "t3_sat_out", val, d == 0 ? 24576 : -32768);
         check(d == 0 ? "t3_wrap_ovf" : "t3_sat_ovf", ovf, 1);
      end
      send_beat(1, fill(8'sd1), 1'b1, 1'b1, 16'sd0);
      wait_result(1, "t3c", lat, val, ovf);
      check("t3c_out", val, 32);
      check("t3c_ovf_cleared", ovf, 0);

      // back-to-back single-beat frames with the consumer stalled
      @(negedge clk);
      out_ready_v[0] = 1'b0;
      send_beat(0, fill(8'sd1), 1'b1, 1'b1, 16'sd0);
      send_beat(0, fill(8'sd1), 1'b1, 1'b1, 16'sd5);
      wait_result(0, "t4a", lat, val, ovf);
      check("t4a_out", val, 32);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("t4_in_ready_held", in_ready_v[0], 0);
         check("t4_out_held", out_v[0], 32);
         check("t4_valid_held", out_valid_v[0], 1);
      end
      out_ready_v[0] = 1'b1;
      @(negedge clk);
      check("t4b_valid", out_valid_v[0], 1);
      check("t4b_out", out_v[0], 37);
      @(negedge clk);
      check("t4_drop", out_valid_v[0], 0);

      // first reasserted mid-frame discards the partial sum
      send_beat(0, fill(8'sd10), 1'b1, 1'b0, 16'sd0);
      send_beat(0, fill(8'sd1), 1'b1, 1'b1, 16'sd0);
      wait_result(0, "t5", lat, val, ovf);
      check("t5_out", val, 32);

      // REG_EVERY=2 result held, then async reset with dut0 holding 3 beats in flight
      @(negedge clk);
      out_ready_v[2] = 1'b0;
      send_beat(2, fill(8'sd1), 1'b1, 1'b1, 16'sd0);
      wait_result(2, "t6a", lat, val, ovf);
      check("t6a_latency", lat, 4);
      check("t6a_out", val, 32);
      send_beat(0, fill(8'sd3), 1'b1, 1'b0, 16'sd0);
      send_beat(0, fill(8'sd3), 1'b0, 1'b0, 16'sd0);
      send_beat(0, fill(8'sd3), 1'b0, 1'b1, 16'sd0);
      #2;
      reset = 1'b0;
      in_valid_v[0] = 1'b0;
      #1;
      check("t6_async_valid", out_valid_v[2], 0);
      check("t6_async_out", out_v[2], 0);
      check("t6_async_valid0", out_valid_v[0], 0);
      @(negedge clk);
      reset = 1'b1;
      out_ready_v[2] = 1'b1;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid_v[0]) cnt++;
      end
      check("t6_no_ghost", cnt, 0);
      send_beat(0, fill(8'sd2), 1'b0, 1'b1, 16'sd7);
      wait_result(0, "t6b", lat, val, ovf);
      check("t6b_latency", lat, 6);
      check("t6b_out", val, 64);
      send_beat(2, fill(8'sd2), 1'b1, 1'b1, 16'sd0);
      wait_result(2, "t6c", lat, val, ovf);
      check("t6c_latency", lat, 4);
      check("t6c_out", val, 64);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipelined_accum_adder_tree.md
Name: pipelined_accum_adder_tree

Overview:
- Parametrised successor to the fixed 32-input tree.
- Reduces FTSIZE signed INPUT_WIDTH lanes to one sum per beat through a log2-depth tree with configurable register spacing.
- Accumulates sums over a multi-beat frame, framed by first/last flags, adding a bias on the first beat.
- Sits between the HD encoder lanes and the dimension accumulator memory. Uses a valid/ready handshake with full-pipeline stall and optional saturation.

Parameters:
- INPUT_WIDTH, 8, signed lane width.
- DIM_WIDTH, 16, signed accumulator/output width; must be >= INPUT_WIDTH + log2(FTSIZE).
- FTSIZE, 32, lane count; power of two, >= 2.
- REG_EVERY, 1, tree levels per pipeline register (1..D, where D = log2(FTSIZE)).
- SATURATE, 0, 1 = clamp accumulator to signed DIM_WIDTH range; 0 = two's-complement wrap.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inputs  in  FTSIZE x INPUT_WIDTH  signed lanes.
- last_in  in  DIM_WIDTH  signed bias, added on the first beat of a frame.
- in_valid  in  1  beat present.
- in_first  in  1  beat opens a frame.
- in_last  in  1  beat closes a frame.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- out  out  DIM_WIDTH  frame result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- overflow  out  1  frame result clamped or wrapped; valid with out.

Behaviour:
- Reset (reset low, async): out = 0, out_valid = 0, overflow = 0, every stage valid bit cleared, accumulator = 0, frame-open flag = 0. in_ready = 1 after deassertion. Reset mid-frame discards all in-flight beats and partial sums.
- Lanes are sign-extended to TW = INPUT_WIDTH + D bits. The tree is overflow-free at TW.
- Pipeline register after tree level k when k % REG_EVERY == 0 or k == D. This gives P = ceil(D / REG_EVERY) tree stages.
- Each stage carries valid, first, last and last_in alongside the data.
- Accumulator stage, one register, on a valid beat:
  - first = 1: acc = sext(sum) + last_in, regardless of the open flag. An open frame is discarded (restart).
  - first = 0: acc = acc + sext(sum). If no frame is open, the beat is treated as first with bias 0.
- Overflow detection: the full-precision (DIM_WIDTH + 1) add result falls outside the signed DIM_WIDTH range.
  - SATURATE = 1: clamp to 2^(DIM_WIDTH-1) - 1 or -2^(DIM_WIDTH-1).
  - SATURATE = 0: keep the low DIM_WIDTH bits.
  - A frame-sticky overflow bit is set in either mode and cleared at frame open.
- last = 1 at the accumulator: out <= new acc, overflow <= sticky | this-beat overflow, out_valid <= 1, frame closes.
- first && last on one beat is a single-beat frame: out = sum + last_in.
- Latency: an accepted last beat gives out_valid exactly P + 1 cycles later (no stall). With defaults, P = 5 and latency = 6.
- Throughput: one beat per cycle.
- Stall: en = !(out_valid && !out_ready). When en = 0, all tree stages, the accumulator and the output hold, and in_ready = 0. Bubbles propagate with valid = 0.
- When out_valid && out_ready, out_valid drops next cycle unless a new result loads in that same cycle, in which case it stays 1 with the new value.
- in_valid = 0 beats never alter the accumulator.
- Inputs are sampled only on the handshake.

Decomposition:
- Package hd_tree_pkg holds: the clog2-derived constants D and TW, a function for the stage-register predicate, and the saturate/overflow function.
- Sub-module tree_level_reduce(N, W, REG) performs one level: N to N/2 pairwise adds, optional register, and valid/sideband forwarding with enable. The top instantiates D levels in a generate loop.

Test Plan (defaults unless noted):
- Single-beat frame, lanes 0-3 = -1 and 4-7 = +1 repeated, last_in = 3, first = last = 1 -> out = 3, overflow = 0, out_valid 6 cycles after acceptance.
- 3-beat frame, all lanes 127, last_in = 0, back-to-back beats -> out = 12192, one out_valid pulse.
- 10-beat frame, all lanes -128 -> SATURATE = 1: out = -32768, overflow = 1. SATURATE = 0: out = 24576, overflow = 1.
- Two back-to-back single-beat frames (all lanes 1, last_in = 0 then 5) with out_ready low 4 cycles -> in_ready low while held, results 32 then 37, none lost or duplicated.
- in_first reasserted mid-frame (beat 1 lanes 10, beat 2 first = 1 lanes 1, last = 1, last_in = 0) -> out = 32 (partial discarded).
- reset pulsed low mid-frame with 3 beats in flight -> out_valid = 0 immediately. The next 1-beat frame of lanes 2 gives out = 64. REG_EVERY = 2 gives latency 4.
